// File: rtl/ex_muldiv_sequencer.sv
// ex_muldiv_sequencer: multi-cycle RV32M multiply/divide controller beside the EX ALU.
// It runs an iterative shift-add multiplier or restoring divider and stalls the
// pipeline through ex_clk_en until the result is ready.
// Build option: define MULDIV_FAST_MUL_EN to compute MUL* in one cycle; divides stay iterative.
module ex_muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clk_en_in,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            ex_clk_en,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_t;

  state_t          state_q, state_d;
  op_t             op_in, op_q;
  logic            neg_q;
  logic [XLEN-1:0] acc_hi_q, acc_lo_q, opb_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] result_q;
  logic            hold;

  // Operand decode on the incoming op
  logic            signed_a, signed_b, s1, s2, neg_in, is_div, special, fast_take;
  logic [XLEN-1:0] abs_a, abs_b, special_res, fast_res;
  logic            accept;

  // One iteration of the shared datapath and the final-result fixup
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [XLEN-1:0]   step_hi, step_lo, quo_fin, rem_fin;
  logic [2*XLEN-1:0] prod, prod_fin;
  logic [XLEN-1:0]   final_res;

  assign op_in = op_t'(op);

  // Operand signs, magnitudes and the div-by-zero / overflow shortcuts
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    signed_a    = (op_in == OP_MULH) || (op_in == OP_MULHSU) || (op_in == OP_DIV) || (op_in == OP_REM);
    signed_b    = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    s1          = signed_a & src1[XLEN-1];
    s2          = signed_b & src2[XLEN-1];
    abs_a       = s1 ? -src1 : src1;
    abs_b       = s2 ? -src2 : src2;
    // Remainder follows the dividend only; everything else negates on differing signs.
    neg_in      = (op_in == OP_REM) ? s1 : (s1 ^ s2);
    is_div      = op[2];
    special     = 1'b0;
    special_res = '0;
    if (is_div && (src2 == '0)) begin
      special     = 1'b1;
      special_res = op[1] ? src1 : '1;
    end else if (((op_in == OP_DIV) || (op_in == OP_REM)) &&
                 (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1)) begin
      special     = 1'b1;
      special_res = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  // Single-cycle full-width product; two's complement wraps correctly modulo 2^(2*XLEN)
  always_comb begin
    fast_a    = {{XLEN{s1}}, src1};
    fast_b    = {{XLEN{s2}}, src2};
    fast_prod = fast_a * fast_b;
    fast_take = ~is_div;
    fast_res  = (op_in == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end
`else
  assign fast_take = 1'b0;
  assign fast_res  = '0;
`endif

  assign accept = (state_q == S_IDLE) && start && clk_en_in && !flush;

  // Iteration step: shift-add multiply or restoring divide over {acc_hi, acc_lo}
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    if (op_q[2]) begin
      if (!div_diff[XLEN]) begin
        step_hi = div_diff[XLEN-1:0];
        step_lo = {acc_lo_q[XLEN-2:0], 1'b1};
      end else begin
        step_hi = div_shift[XLEN-1:0];
        step_lo = {acc_lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], acc_lo_q[XLEN-1:1]};
    end
    prod      = {step_hi, step_lo};
    prod_fin  = neg_q ? -prod : prod;
    quo_fin   = neg_q ? -step_lo : step_lo;
    rem_fin   = neg_q ? -step_hi : step_hi;
    if (op_q[2])
      final_res = op_q[1] ? rem_fin : quo_fin;
    else
      final_res = (op_q == OP_MUL) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and pipeline hold
  always_comb begin
    state_d = state_q;
    hold    = 1'b0;
    case (state_q)
      S_IDLE: begin
        hold = start;
        if (accept) state_d = (special || fast_take) ? S_DONE : S_BUSY;
      end
      S_BUSY: begin
        hold = 1'b1;
        if (clk_en_in && (cnt_q == CW'(1))) state_d = S_DONE;
      end
      S_DONE: begin
        if (clk_en_in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Operand latch, iteration and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q     <= op_in;
      neg_q    <= neg_in;
      acc_hi_q <= '0;
      acc_lo_q <= abs_a;
      opb_q    <= abs_b;
      cnt_q    <= CW'(XLEN);
      if (special)        result_q <= special_res;
      else if (fast_take) result_q <= fast_res;
    end else if ((state_q == S_BUSY) && clk_en_in && !flush) begin
      acc_hi_q <= step_hi;
      acc_lo_q <= step_lo;
      cnt_q    <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) result_q <= final_res;
    end
  end

  assign ex_clk_en = clk_en_in & ~hold;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// tb_ex_muldiv_sequencer: scoreboard bench for ex_muldiv_sequencer. A reference model
// pushes the expected result and latency when an op is driven; they are popped
// and compared when done rises.
module tb_ex_muldiv_sequencer;

  localparam int XLEN = 32;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            clk_en_in;
  logic            flush;
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] src1, src2;
  logic            ex_clk_en, busy, done;
  logic [XLEN-1:0] result;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  ex_muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_en_in (clk_en_in),
    .flush     (flush),
    .start     (start),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .ex_clk_en (ex_clk_en),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0]        p;
    logic signed [31:0] sa, sb_;
    sa  = a;
    sb_ = b;
    case (o)
      3'd0: begin p = {32'b0, a} * {32'b0, b};                     return p[31:0];  end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b};         return p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b};               return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b};                     return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb_;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return sa % sb_;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && b == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!o[2]) return 1;
`endif
    return XLEN + 1;
  endfunction

  // Drive one op from IDLE; clk_en_in is low for cycles ce_lo..ce_hi and, if
  // done_hold>0, also held low for that many cycles once done appears.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int ce_lo, input int ce_hi, input int done_hold);
    exp_t        e;
    exp_t        got_e;
    int          cyc;
    int          stall_bad;
    logic        seen;
    logic [31:0] held;
    e.res = model(o, a, b);
    e.lat = model_lat(o, a, b) + ((ce_hi >= ce_lo) ? (ce_hi - ce_lo + 1) : 0);
    sb.push_back(e);
    op = o; src1 = a; src2 = b; start = 1'b1;
    cyc = 0; stall_bad = 0; seen = 1'b0;
    while (cyc < 200 && !seen) begin
      clk_en_in = (cyc >= ce_lo && cyc <= ce_hi) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        if (ex_clk_en !== 1'b0) stall_bad++;
        @(posedge clk); #1;
        cyc++;
      end
    end
    check("done_seen", {31'b0, seen}, 32'd1);
    if (!seen) begin
      start = 1'b0;
      clk_en_in = 1'b1;
      void'(sb.pop_front());
      return;
    end
    got_e = sb.pop_front();
    check("result", result, got_e.res);
    check("latency", cyc, got_e.lat);
    check("stall_cycles_bad", stall_bad, 0);
    check("ex_clk_en_in_done", {31'b0, ex_clk_en}, 32'd1);
    if (done_hold > 0) begin
      held = result;
      clk_en_in = 1'b0;
      for (int k = 0; k < done_hold; k++) begin
        @(posedge clk); #1;
        @(negedge clk);
        check("done_held", {31'b0, done}, 32'd1);
        check("result_held", result, held);
      end
      clk_en_in = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("idle_after", {30'b0, busy, done}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; clk_en_in = 1'b1; flush = 1'b0; start = 1'b0;
    op = 3'd0; src1 = '0; src2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_ex_clk_en", {31'b0, ex_clk_en}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    run_op(3'd0, 32'h7, 32'hFFFF_FFFD, -1, -2, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -2, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'h2, -1, -2, 0);
    run_op(3'd1, 32'hFFFF_FFF9, 32'h0000_0003, -1, -2, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'h2, -1, -2, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'h2, -1, -2, 0);
    run_op(3'd5, 32'h5, 32'h0, -1, -2, 0);
    run_op(3'd6, 32'h5, 32'h0, -1, -2, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, -1, -2, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, -1, -2, 0);
    run_op(3'd7, 32'hFFFF_FFFF, 32'h10, -1, -2, 0);
    // Freeze during BUSY, then hold in DONE
    run_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 4, 8, 0);
    run_op(3'd5, 32'hDEAD_BEEF, 32'h1234, -1, -2, 3);

    // Flush at cycle 10 of a DIV
    op = 3'd4; src1 = 32'd1000; src2 = 32'd7; start = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_ex_clk_en", {31'b0, ex_clk_en}, 32'd1);
    begin
      int done_cnt = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (done) done_cnt++;
      end
      check("flush_no_done", done_cnt, 0);
    end
    @(posedge clk); #1;

    // Async reset at cycle 5 of a MUL
    op = 3'd0; src1 = 32'h55; src2 = 32'h66; start = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_result", result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    run_op(3'd0, 32'h55, 32'h66, -1, -2, 0);

    // Random ops, with some small or zero divisors
    for (int i = 0; i < 14; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 1) rb = 32'($urandom_range(0, 9));
      if (i % 4 == 3) rb = -32'($urandom_range(1, 9));
      run_op(ro, ra, rb, -1, -2, 0);
    end

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
